alarm_controller: RTL

Top-level sequencing FSM of the alarm control center. It arms and disarms the system, runs the exit and entry delays, watches the sensor zones and decides when to raise the alarm. The `aux` output drives the LED alarm blinker (1 = blink, 0 = LEDs steady on). The `siren` output drives the audible output.

---
 rtl/alarm_controller.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/alarm_controller.sv
// alarm_controller: top-level sequencing FSM of the alarm control center.
// Handles arming/disarming, exit and entry delays, zone supervision and the
// alarm period with automatic re-arm attempts. All outputs are registered.
module alarm_controller #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int N_ZONES       = 4,
  parameter int EXIT_DELAY_S  = 30,
  parameter int ENTRY_DELAY_S = 15,
  parameter int ALARM_TIME_S  = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm_req,
  input  logic               disarm_req,
  input  logic               code_ok,
  input  logic [N_ZONES-1:0] zone_in,
  input  logic [N_ZONES-1:0] zone_delay,
  output logic [2:0]         state,
  output logic               armed,
  output logic               entry_warn,
  output logic               aux,
  output logic               siren,
  output logic               fault,
  output logic [N_ZONES-1:0] zone_latch
);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_t;

  localparam logic [25:0] PRE_LAST   = 26'(CLK_HZ - 1);
  localparam logic [6:0]  EXIT_LAST  = 7'(EXIT_DELAY_S - 1);
  localparam logic [6:0]  ENTRY_LAST = 7'(ENTRY_DELAY_S - 1);
  localparam logic [6:0]  ALARM_LAST = 7'(ALARM_TIME_S - 1);
  localparam logic [N_ZONES-1:0] ZONES_CLR = {N_ZONES{1'b0}};

  state_t             state_q, state_d;
  logic [25:0]        pre_q, pre_d;
  logic [6:0]         sec_q, sec_d;
  logic [N_ZONES-1:0] zone_latch_q, zone_latch_d;
  logic               fault_q, fault_d;
  logic               armed_q, armed_d;
  logic               entry_warn_q, entry_warn_d;
  logic               alarm_q, alarm_d;

  logic               valid_disarm_s;
  logic               tick_s;
  logic               restart_s;
  logic               instant_hit_s;
  logic               delayed_hit_s;

  // Next-state, timebase, zone latch and output decode.
  always_comb begin
    state_d        = state_q;
    pre_d          = pre_q;
    sec_d          = sec_q;
    zone_latch_d   = zone_latch_q;
    fault_d        = 1'b0;
    restart_s      = 1'b0;
    valid_disarm_s = disarm_req && code_ok;
    tick_s         = (pre_q == PRE_LAST);
    instant_hit_s  = |(zone_in & ~zone_delay);
    delayed_hit_s  = |(zone_in & zone_delay);

    // Sticky record of every zone seen open while the system is armed.
    if (state_q == S_ARMED || state_q == S_ENTRY || state_q == S_ALARM) begin
      zone_latch_d = zone_latch_q | zone_in;
    end else begin
      zone_latch_d = zone_latch_q;
    end

    if (valid_disarm_s) begin
      state_d = S_DISARMED;
    end else begin
      case (state_q)
        S_DISARMED: begin
          if (arm_req) begin
            if (zone_in == ZONES_CLR) begin
              state_d      = S_EXIT;
              zone_latch_d = ZONES_CLR;
            end else begin
              fault_d = 1'b1;
            end
          end else begin
            state_d = S_DISARMED;
          end
        end
        S_EXIT: begin
          if (tick_s && sec_q == EXIT_LAST) begin
            state_d = S_ARMED;
          end else begin
            state_d = S_EXIT;
          end
        end
        S_ARMED: begin
          if (instant_hit_s) begin
            state_d = S_ALARM;
          end else if (delayed_hit_s) begin
            state_d = S_ENTRY;
          end else begin
            state_d = S_ARMED;
          end
        end
        S_ENTRY: begin
          if (instant_hit_s || (tick_s && sec_q == ENTRY_LAST)) begin
            state_d = S_ALARM;
          end else begin
            state_d = S_ENTRY;
          end
        end
        S_ALARM: begin
          if (tick_s && sec_q == ALARM_LAST) begin
            if (zone_in == ZONES_CLR) begin
              state_d = S_ARMED;
            end else begin
              restart_s = 1'b1;
            end
          end else begin
            state_d = S_ALARM;
          end
        end
        default: begin
          state_d = S_DISARMED;
        end
      endcase
    end

    // Timebase clears on any transition or alarm restart, otherwise counts.
    if (state_d != state_q || restart_s) begin
      pre_d = 26'd0;
      sec_d = 7'd0;
    end else if (tick_s) begin
      pre_d = 26'd0;
      sec_d = sec_q + 7'd1;
    end else begin
      pre_d = pre_q + 26'd1;
      sec_d = sec_q;
    end

    armed_d      = (state_d == S_ARMED) || (state_d == S_ENTRY) || (state_d == S_ALARM);
    entry_warn_d = (state_d == S_ENTRY);
    alarm_d      = (state_d == S_ALARM);
  end

  // State, timebase and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_DISARMED;
      pre_q        <= 26'd0;
      sec_q        <= 7'd0;
      zone_latch_q <= ZONES_CLR;
      fault_q      <= 1'b0;
      armed_q      <= 1'b0;
      entry_warn_q <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      sec_q        <= sec_d;
      zone_latch_q <= zone_latch_d;
      fault_q      <= fault_d;
      armed_q      <= armed_d;
      entry_warn_q <= entry_warn_d;
      alarm_q      <= alarm_d;
    end
  end

  assign state      = state_q;
  assign armed      = armed_q;
  assign entry_warn = entry_warn_q;
  assign aux        = alarm_q;
  assign siren      = alarm_q;
  assign fault      = fault_q;
  assign zone_latch = zone_latch_q;

endmodule
